// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider.
//   DEFAULT_WIDTH - default operand/result width in bits
//   div_state_t   - divider FSM states
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    CALC = 2'd2,
    FIX  = 2'd3
  } div_state_t;

endpackage

// File: rtl/seq_divider_cond_negate.sv
// Conditional two's-complement negator.
// Ports:
//   value  - WIDTH-bit operand
//   enable - 1 = output the two's complement of value, 0 = pass through
//   result - WIDTH-bit result
module cond_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             enable,
  output logic [WIDTH-1:0] result
);

  assign result = enable ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, signed (DIV) or unsigned (DIVU).
// An accepted start is followed by one PREP cycle (operand magnitudes),
// WIDTH CALC cycles (one quotient bit each) and one FIX cycle (sign
// correction), so done pulses WIDTH+2 edges after the accepting edge.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start               - request, only sampled in IDLE
//   is_signed           - 1 = signed divide, 0 = unsigned; sampled with start
//   dividend, divisor   - operands, sampled with start
//   busy                - high while an operation is in progress
//   done                - one-cycle pulse when results are updated
//   quotient, remainder - results, held until the next done
//   div_zero            - divisor was zero; updated with the results
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_t state_q;
  div_state_t state_d;

  // num_q holds the dividend and is shifted left one bit per CALC step,
  // so it ends up holding the quotient bits.
  logic [WIDTH-1:0] num_q;
  logic [WIDTH-1:0] den_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] orig_dividend_q;
  logic [CNT_W-1:0] cnt_q;
  logic             signed_q;
  logic             sign_quot_q;
  logic             sign_rem_q;
  logic             zero_q;

  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             div_zero_q;
  logic             done_q;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;

  logic             neg_a_en;
  logic [WIDTH-1:0] neg_a_out;
  logic [WIDTH-1:0] neg_b_in;
  logic             neg_b_en;
  logic [WIDTH-1:0] neg_b_out;

  // The state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = PREP;
      PREP: state_d = CALC;
      CALC: if (cnt_q == LAST_CNT) state_d = FIX;
      FIX:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The two negators are shared between PREP and FIX. Negator A always
  // works on num_q (the dividend in PREP, the quotient in FIX); negator B
  // works on the divisor in PREP and on the remainder in FIX.
  always_comb begin
    neg_a_en = 1'b0;
    neg_b_in = rem_q;
    neg_b_en = 1'b0;
    case (state_q)
      PREP: begin
        neg_a_en = signed_q & num_q[WIDTH-1];
        neg_b_in = den_q;
        neg_b_en = signed_q & den_q[WIDTH-1];
      end
      FIX: begin
        neg_a_en = sign_quot_q;
        neg_b_en = sign_rem_q;
      end
      default: ;
    endcase
  end

  cond_negate #(.WIDTH(WIDTH)) u_neg_a (
    .value  (num_q),
    .enable (neg_a_en),
    .result (neg_a_out)
  );

  cond_negate #(.WIDTH(WIDTH)) u_neg_b (
    .value  (neg_b_in),
    .enable (neg_b_en),
    .result (neg_b_out)
  );

  // One restoring step: the partial remainder is widened to WIDTH+1 bits
  // so a divisor with its MSB set is compared correctly. A borrow out of
  // the top bit means the trial subtraction failed and the shifted value
  // is kept. The kept remainder is always below the divisor, so WIDTH
  // bits are enough to store it between steps.
  assign rem_shift = {rem_q, num_q[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, den_q};

  // Datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q           <= '0;
      den_q           <= '0;
      rem_q           <= '0;
      orig_dividend_q <= '0;
      cnt_q           <= '0;
      signed_q        <= 1'b0;
      sign_quot_q     <= 1'b0;
      sign_rem_q      <= 1'b0;
      zero_q          <= 1'b0;
      quotient_q      <= '0;
      remainder_q     <= '0;
      div_zero_q      <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      done_q <= (state_q == FIX);
      case (state_q)
        IDLE: begin
          if (start) begin
            num_q           <= dividend;
            den_q           <= divisor;
            orig_dividend_q <= dividend;
            signed_q        <= is_signed;
            zero_q          <= (divisor == '0);
          end
        end
        PREP: begin
          num_q       <= neg_a_out;
          den_q       <= neg_b_out;
          sign_quot_q <= signed_q & (num_q[WIDTH-1] ^ den_q[WIDTH-1]);
          sign_rem_q  <= signed_q & num_q[WIDTH-1];
          rem_q       <= '0;
          cnt_q       <= '0;
        end
        CALC: begin
          if (rem_diff[WIDTH]) begin
            rem_q <= rem_shift[WIDTH-1:0];
            num_q <= {num_q[WIDTH-2:0], 1'b0};
          end else begin
            rem_q <= rem_diff[WIDTH-1:0];
            num_q <= {num_q[WIDTH-2:0], 1'b1};
          end
          cnt_q <= (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
        end
        FIX: begin
          // A zero divisor reports all-ones and the untouched dividend
          // in both modes, bypassing the sign correction.
          quotient_q  <= zero_q ? '1 : neg_a_out;
          remainder_q <= zero_q ? orig_dividend_q : neg_b_out;
          div_zero_q  <= zero_q;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH = 32). Expected results come
// from plain integer arithmetic on the operands.
module tb_seq_divider;

  localparam int W = 32;
  localparam int LATENCY = W + 2;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  int total = 0;
  int bad   = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: zero divisor gives all-ones / dividend; otherwise integer
  // division truncating toward zero, done in 64 bits so -2^31 / -1 does
  // not overflow before being cut back to 32 bits.
  function automatic void refDivide(input logic sgn, input logic [W-1:0] a,
                                    input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa;
    longint sb;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                             input logic [W-1:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Presents a request at the falling edge, lets the next rising edge take
  // it and returns 1 ns after that edge with start still high when hold=1.
  task automatic applyStimulus(input logic sgn, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic hold);
    @(negedge clk);
    start     = 1'b1;
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Counts rising edges until done shows up (bounded), noting whether busy
  // stayed high on every edge before it.
  task automatic waitDone(output int edges, output logic busyOk);
    edges  = 0;
    busyOk = 1'b1;
    while (!done && edges < 80) begin
      @(posedge clk);
      #1;
      edges++;
      if (!done && !busy) busyOk = 1'b0;
    end
  endtask

  task automatic checkResult(input string tag, input logic sgn, input logic [W-1:0] a,
                             input logic [W-1:0] b, input int edges, input logic busyOk);
    logic [W-1:0] expQ;
    logic [W-1:0] expR;
    refDivide(sgn, a, b, expQ, expR);
    checkOutput({tag, "_latency"}, W'(edges), W'(LATENCY));
    checkOutput({tag, "_busy_during"}, W'(busyOk), W'(1));
    checkOutput({tag, "_done"}, W'(done), W'(1));
    checkOutput({tag, "_busy_at_done"}, W'(busy), W'(0));
    checkOutput({tag, "_quotient"}, quotient, expQ);
    checkOutput({tag, "_remainder"}, remainder, expR);
    checkOutput({tag, "_div_zero"}, W'(div_zero), W'(b == '0));
  endtask

  task automatic runOp(input string tag, input logic sgn, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    int   edges;
    logic busyOk;
    applyStimulus(sgn, a, b, 1'b0);
    checkOutput({tag, "_busy_accept"}, W'(busy), W'(1));
    waitDone(edges, busyOk);
    checkResult(tag, sgn, a, b, edges, busyOk);
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_pulse_end"}, W'(done), W'(0));
  endtask

  initial begin
    logic [W-1:0] expQ;
    logic [W-1:0] expR;
    logic [W-1:0] prevQ;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;
    logic         busyOk;
    int           edges;
    int           doneSeen;

    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;

    $display("[TB] reset state");
    #1;
    checkOutput("rst_busy", W'(busy), W'(0));
    checkOutput("rst_done", W'(done), W'(0));
    checkOutput("rst_quotient", quotient, '0);
    checkOutput("rst_remainder", remainder, '0);
    checkOutput("rst_div_zero", W'(div_zero), W'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed operations");
    runOp("u100_7", 1'b0, 32'd100, 32'd7);
    runOp("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    runOp("u_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2);
    runOp("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    runOp("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
    runOp("u5_0", 1'b0, 32'd5, 32'd0);
    runOp("s5_0", 1'b1, 32'd5, 32'd0);
    runOp("s_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0);
    runOp("u_big_div", 1'b0, 32'hFFFF_FFFF, 32'h8000_0000);

    $display("[TB] start re-pulsed while busy");
    prevQ = quotient;
    applyStimulus(1'b0, 32'd1000, 32'd10, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    start     = 1'b1;
    is_signed = 1'b1;
    dividend  = 32'd77;
    divisor   = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("repulse_result_held", quotient, prevQ);
    waitDone(edges, busyOk);
    checkResult("repulse", 1'b0, 32'd1000, 32'd10, edges + 10, busyOk);

    $display("[TB] start held across done");
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 32'd50, 32'd6, 1'b1);
    is_signed = 1'b1;
    dividend  = 32'hFFFF_FF9C;
    divisor   = 32'd7;
    waitDone(edges, busyOk);
    checkResult("held_first", 1'b0, 32'd50, 32'd6, edges, busyOk);
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("held_second_accepted", W'(busy), W'(1));
    checkOutput("held_done_pulse_end", W'(done), W'(0));
    waitDone(edges, busyOk);
    checkResult("held_second", 1'b1, 32'hFFFF_FF9C, 32'd7, edges, busyOk);

    $display("[TB] reset mid-operation");
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 32'd12345, 32'd11, 1'b0);
    repeat (14) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", W'(busy), W'(0));
    checkOutput("midrst_done", W'(done), W'(0));
    checkOutput("midrst_quotient", quotient, '0);
    checkOutput("midrst_remainder", remainder, '0);
    checkOutput("midrst_div_zero", W'(div_zero), W'(0));
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    doneSeen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) doneSeen++;
    end
    checkOutput("midrst_no_done", W'(doneSeen), W'(0));
    runOp("after_rst_9_3", 1'b0, 32'd9, 32'd3);

    $display("[TB] random operations");
    for (int i = 0; i < 24; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 15));
        2:       rb = '1;
        3:       rb = W'($urandom_range(1, 1000)) | 32'h8000_0000;
        default: rb = $urandom;
      endcase
      refDivide(rs, ra, rb, expQ, expR);
      runOp($sformatf("rand%0d", i), rs, ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
